// File: rtl/jtag_sequence_monitor_if.sv
// Pin and status bundle between the JTAG sequence monitor and whoever drives or observes it.
interface jtag_sequence_monitor_if #(
    parameter int unsigned pPATTERN_WIDTH = 16
);
    logic                      tck_in;
    logic                      tms_in;
    logic [pPATTERN_WIDTH-1:0] pattern;
    logic                      arm;
    logic                      armed;
    logic                      line_reset;
    logic                      match;
    logic                      mismatch;
    logic [pPATTERN_WIDTH-1:0] captured;
    logic [3:0]                tap_state;
    logic [7:0]                ones_count;

    modport master (
        output tck_in, tms_in, pattern, arm,
        input  armed, line_reset, match, mismatch, captured, tap_state, ones_count
    );

    modport slave (
        input  tck_in, tms_in, pattern, arm,
        output armed, line_reset, match, mismatch, captured, tap_state, ones_count
    );
endinterface

// File: rtl/jtag_sequence_monitor.sv
// Passive TCK/TMS observer: oversampled TAP tracker, TMS line-reset detector and
// post-reset TMS pattern capture/compare for checking the sequence generator.
module jtag_sequence_monitor #(
    parameter int unsigned pPATTERN_WIDTH = 16,
    parameter int unsigned pMIN_ONES      = 50,
    parameter int unsigned pSYNC_STAGES   = 2
) (
    input logic                     clk,
    input logic                     reset_n,
    jtag_sequence_monitor_if.slave  bus
);

    localparam int unsigned IDX_W  = (pPATTERN_WIDTH > 1) ? $clog2(pPATTERN_WIDTH) : 1;
    localparam int unsigned CNT_W  = 8;
    localparam logic [CNT_W-1:0] ONES_MAX = '1;
    localparam logic [CNT_W-1:0] MIN_ONES = CNT_W'(pMIN_ONES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(pPATTERN_WIDTH - 1);

    typedef enum logic [3:0] {
        TAP_TLR      = 4'd0,
        TAP_RTI      = 4'd1,
        TAP_SEL_DR   = 4'd2,
        TAP_CAP_DR   = 4'd3,
        TAP_SHIFT_DR = 4'd4,
        TAP_EX1_DR   = 4'd5,
        TAP_PAUSE_DR = 4'd6,
        TAP_EX2_DR   = 4'd7,
        TAP_UPD_DR   = 4'd8,
        TAP_SEL_IR   = 4'd9,
        TAP_CAP_IR   = 4'd10,
        TAP_SHIFT_IR = 4'd11,
        TAP_EX1_IR   = 4'd12,
        TAP_PAUSE_IR = 4'd13,
        TAP_EX2_IR   = 4'd14,
        TAP_UPD_IR   = 4'd15
    } tap_e;

    typedef enum logic [2:0] {
        DET_IDLE,
        DET_WAIT_RESET,
        DET_WAIT_START,
        DET_CAPTURE,
        DET_COMPARE
    } det_e;

    logic [pSYNC_STAGES-1:0]   tck_sync_q, tck_sync_d;
    logic [pSYNC_STAGES-1:0]   tms_sync_q, tms_sync_d;
    logic                      tck_prev_q, tck_prev_d;
    logic [CNT_W-1:0]          ones_q, ones_d;
    tap_e                      tap_q, tap_d;
    det_e                      det_q, det_d;
    logic [IDX_W-1:0]          idx_q, idx_d;
    logic [pPATTERN_WIDTH-1:0] captured_q, captured_d;
    logic                      armed_q, armed_d;
    logic                      line_reset_q, line_reset_d;
    logic                      match_q, match_d;
    logic                      mismatch_q, mismatch_d;
    logic                      tck_s_c, tms_s_c, rise_c;

    function automatic tap_e tap_next(input tap_e s, input logic tms);
        case (s)
            TAP_TLR:      tap_next = tms ? TAP_TLR    : TAP_RTI;
            TAP_RTI:      tap_next = tms ? TAP_SEL_DR : TAP_RTI;
            TAP_SEL_DR:   tap_next = tms ? TAP_SEL_IR : TAP_CAP_DR;
            TAP_CAP_DR:   tap_next = tms ? TAP_EX1_DR : TAP_SHIFT_DR;
            TAP_SHIFT_DR: tap_next = tms ? TAP_EX1_DR : TAP_SHIFT_DR;
            TAP_EX1_DR:   tap_next = tms ? TAP_UPD_DR : TAP_PAUSE_DR;
            TAP_PAUSE_DR: tap_next = tms ? TAP_EX2_DR : TAP_PAUSE_DR;
            TAP_EX2_DR:   tap_next = tms ? TAP_UPD_DR : TAP_SHIFT_DR;
            TAP_UPD_DR:   tap_next = tms ? TAP_SEL_DR : TAP_RTI;
            TAP_SEL_IR:   tap_next = tms ? TAP_TLR    : TAP_CAP_IR;
            TAP_CAP_IR:   tap_next = tms ? TAP_EX1_IR : TAP_SHIFT_IR;
            TAP_SHIFT_IR: tap_next = tms ? TAP_EX1_IR : TAP_SHIFT_IR;
            TAP_EX1_IR:   tap_next = tms ? TAP_UPD_IR : TAP_PAUSE_IR;
            TAP_PAUSE_IR: tap_next = tms ? TAP_EX2_IR : TAP_PAUSE_IR;
            TAP_EX2_IR:   tap_next = tms ? TAP_UPD_IR : TAP_SHIFT_IR;
            TAP_UPD_IR:   tap_next = tms ? TAP_SEL_DR : TAP_RTI;
            default:      tap_next = TAP_TLR;
        endcase
    endfunction

    // Pin synchronizers and TCK rising-edge detect; one sample per rise.
    always_comb begin
        tck_sync_d = {tck_sync_q[pSYNC_STAGES-2:0], bus.tck_in};
        tms_sync_d = {tms_sync_q[pSYNC_STAGES-2:0], bus.tms_in};
        tck_s_c    = tck_sync_q[pSYNC_STAGES-1];
        tms_s_c    = tms_sync_q[pSYNC_STAGES-1];
        tck_prev_d = tck_s_c;
        rise_c     = tck_s_c & ~tck_prev_q;
    end

    // Saturating ones run and free-running TAP tracker.
    always_comb begin
        ones_d = ones_q;
        tap_d  = tap_q;
        if (rise_c) begin
            if (tms_s_c) begin
                ones_d = (ones_q == ONES_MAX) ? ONES_MAX : ones_q + CNT_W'(1);
            end else begin
                ones_d = '0;
            end
            tap_d = tap_next(tap_q, tms_s_c);
        end
    end

    // Detector next-state and outputs; ones_d is the post-update run length.
    always_comb begin
        det_d        = det_q;
        idx_d        = idx_q;
        captured_d   = captured_q;
        armed_d      = armed_q;
        line_reset_d = 1'b0;
        match_d      = 1'b0;
        mismatch_d   = 1'b0;
        case (det_q)
            DET_IDLE: begin
                // A compare pulse is still on the outputs: hold off re-arm one cycle.
                if (bus.arm && !match_q && !mismatch_q) begin
                    det_d   = DET_WAIT_RESET;
                    armed_d = 1'b1;
                end
            end
            DET_WAIT_RESET: begin
                if (rise_c && (ones_d == MIN_ONES)) begin
                    line_reset_d = 1'b1;
                    captured_d   = '0;
                    det_d        = DET_WAIT_START;
                end
            end
            DET_WAIT_START: begin
                if (rise_c && !tms_s_c) begin
                    captured_d[0] = 1'b0;
                    idx_d         = IDX_W'(1);
                    det_d         = (pPATTERN_WIDTH == 1) ? DET_COMPARE : DET_CAPTURE;
                end
            end
            DET_CAPTURE: begin
                if (rise_c) begin
                    captured_d[idx_q] = tms_s_c;
                    idx_d             = idx_q + IDX_W'(1);
                    if (idx_q == LAST_IDX) begin
                        det_d = DET_COMPARE;
                    end
                end
            end
            DET_COMPARE: begin
                match_d    = (captured_q == bus.pattern);
                mismatch_d = (captured_q != bus.pattern);
                armed_d    = 1'b0;
                det_d      = DET_IDLE;
            end
            default: begin
                det_d = DET_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            tck_sync_q   <= '0;
            tms_sync_q   <= '0;
            tck_prev_q   <= 1'b0;
            ones_q       <= '0;
            tap_q        <= TAP_TLR;
            det_q        <= DET_IDLE;
            idx_q        <= '0;
            captured_q   <= '0;
            armed_q      <= 1'b0;
            line_reset_q <= 1'b0;
            match_q      <= 1'b0;
            mismatch_q   <= 1'b0;
        end else begin
            tck_sync_q   <= tck_sync_d;
            tms_sync_q   <= tms_sync_d;
            tck_prev_q   <= tck_prev_d;
            ones_q       <= ones_d;
            tap_q        <= tap_d;
            det_q        <= det_d;
            idx_q        <= idx_d;
            captured_q   <= captured_d;
            armed_q      <= armed_d;
            line_reset_q <= line_reset_d;
            match_q      <= match_d;
            mismatch_q   <= mismatch_d;
        end
    end

    assign bus.armed      = armed_q;
    assign bus.line_reset = line_reset_q;
    assign bus.match      = match_q;
    assign bus.mismatch   = mismatch_q;
    assign bus.captured   = captured_q;
    assign bus.tap_state  = tap_q;
    assign bus.ones_count = ones_q;

endmodule

// File: doc/jtag_sequence_monitor.md
Name: jtag_sequence_monitor

Overview:
- Passive receiver for the JTAG TCK/TMS pins that the bit-banger drives.
- Oversamples TCK/TMS with the system clock, tracks the IEEE 1149.1 TAP state and detects a TMS line-reset run.
- After the line reset, captures a TMS pattern LSB-first and compares it with an expected value.
- Used to loop back and check the TMS sequence generator (e.g. 0xE79E JTAG-to-SWD), and to observe external target traffic.

Parameters:
- pPATTERN_WIDTH, 16, number of TMS bits captured after the line reset (1..255).
- pMIN_ONES, 50, consecutive TMS=1 samples that qualify as a line reset (1..255).
- pSYNC_STAGES, 2, synchronizer depth applied to both tck_in and tms_in (>=2).

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- reset_n  input  1  synchronous, active-low reset.
- tck_in  input  1  asynchronous TCK pin.
- tms_in  input  1  asynchronous TMS pin.
- pattern  input  pPATTERN_WIDTH  expected TMS bits; bit 0 is first on the wire. Must be stable while armed.
- arm  input  1  single-cycle request to start a detection.
- armed  output  1  high from arm acceptance until the compare completes.
- line_reset  output  1  one-cycle pulse when the ones run reaches pMIN_ONES while armed.
- match  output  1  one-cycle pulse: captured bits equal pattern.
- mismatch  output  1  one-cycle pulse: captured bits differ from pattern.
- captured  output  pPATTERN_WIDTH  last captured bits; held until the next capture starts.
- tap_state  output  4  current TAP state.
- ones_count  output  8  current run of consecutive TMS=1 samples, saturating.

Behaviour:
- Reset (reset_n=0 at a clk edge): armed=0, line_reset=0, match=0, mismatch=0, captured=0, tap_state=0 (TEST_LOGIC_RESET), ones_count=0, synchronizers cleared to 0, detector FSM in IDLE.
- Reset mid-capture aborts the capture with no pulse.
- Sampling:
  - tck_in and tms_in pass through identical pSYNC_STAGES flop chains.
  - rise = (synchronized tck == 1) and (its previous value == 0).
  - On a rise cycle the synchronized tms is the sample. Exactly one sample per TCK rising edge.
  - No sample is taken when a rise coincides with reset.
- ones_count updates on each sample: TMS=1 gives min(ones_count+1, 255); TMS=0 gives 0.
- TAP tracker updates on each sample using the standard 1149.1 transition table.
- tap_state encoding:
  - 0 TLR, 1 RTI, 2 SEL_DR, 3 CAP_DR, 4 SHIFT_DR, 5 EX1_DR, 6 PAUSE_DR, 7 EX2_DR, 8 UPD_DR
  - 9 SEL_IR, 10 CAP_IR, 11 SHIFT_IR, 12 EX1_IR, 13 PAUSE_IR, 14 EX2_IR, 15 UPD_IR
  - The tracker always runs, independent of arm.
- Detector FSM states: IDLE, WAIT_RESET, WAIT_START, CAPTURE, COMPARE.
  - IDLE: arm=1 moves to WAIT_RESET and sets armed=1 the next cycle.
  - WAIT_RESET: on the sample where ones_count becomes pMIN_ONES (the value after update equals pMIN_ONES), pulse line_reset and move to WAIT_START. A run already at or above pMIN_ONES when arm arrives does not qualify; the count must cross pMIN_ONES while armed.
  - WAIT_START: further TMS=1 samples are ignored. The first TMS=0 sample is written to captured[0], bit index becomes 1, and the FSM moves to CAPTURE. Patterns therefore must have pattern[0]=0.
  - CAPTURE: each sample is written to captured[index] and index increments. The sample written to index pPATTERN_WIDTH-1 moves the FSM to COMPARE. Ones runs inside CAPTURE have no effect. For pPATTERN_WIDTH=1, the move from WAIT_START goes straight to COMPARE.
  - COMPARE (one clk): pulse match if captured==pattern, otherwise pulse mismatch. armed drops in the same cycle and the FSM returns to IDLE.
- captured clears to 0 on entry to WAIT_START.
- arm while not in IDLE is ignored.
- arm in the same cycle as a COMPARE pulse is ignored; re-arm is accepted from the next cycle.
- Latency:
  - A pin edge appears as rise pSYNC_STAGES+1 clk cycles later.
  - ones_count and tap_state update in the clk after rise.
  - line_reset is asserted in the clk after its qualifying rise.
  - match/mismatch are asserted 2 clk after the rise of the last bit.
- TCK must be high and low for at least pSYNC_STAGES+1 clk each. Faster TCK is out of spec and no behaviour is guaranteed.

Test Plan:
- Reset check: hold reset_n=0 for 3 clk while toggling pins -> every output is 0. Release -> ones_count stays 0 until the first rise.
- Loopback 0xE79E: arm, then drive 64 ones, pattern 0xE79E LSB-first, 64 ones at TCK=clk/8 -> one line_reset pulse at ones=50, then one match pulse, captured=0xE79E, armed drops.
- Corruption: same sequence with pattern bit 5 flipped -> mismatch pulse, captured=0xE7BE, no match pulse.
- Short run: arm, 49 ones, then 0 -> no line_reset, ones_count returns to 0, still armed. Then 50 ones -> line_reset fires.
- TAP walk: from TLR drive TMS 0,1,0,0 -> tap_state sequence 1,2,3,4. Then 5 ones -> tap_state=0. ones_count saturates at 255 after 300 ones.
- Mid-capture reset, and arm while busy: assert reset_n=0 after 8 pattern bits -> no pulse, armed=0, FSM in IDLE. Separately, an arm pulse during CAPTURE has no effect.
